sar_search_ctrl: RTL and testbench

Successive-approximation search controller. It is the driving end of the combinational 3-way magnitude comparator (gt/eq/lt) used in this library. It presents a trial word to an external comparator, reads back the 3-way result, and binary-searches MSB-first for the value of the comparator's other operand. A start/busy/done handshake connects it to the surrounding control logic.

---
 rtl/sar_pkg.sv | 23 ++
 rtl/sar_search_ctrl.sv | 136 +++++++++++++
 tb/tb_sar_search_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// +----------------------------------------------------------------------------+
// | sar_pkg : shared types and helpers for the SAR search controller           |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CMP_LAT_MAX = 3;

  function automatic logic onehot3(input logic gt, input logic eq, input logic lt);
    return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) || ({gt, eq, lt} == 3'b001);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_search_ctrl.sv
// +----------------------------------------------------------------------------+
// | sar_search_ctrl : MSB-first successive-approximation search driving an     |
// | external 3-way comparator, with start/busy/done handshake.                 |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CMP_LAT = 1
) (
  input  logic             clk_pad,
  input  logic             rst_pad,
  input  logic             start_pad,
  output logic [WIDTH-1:0] trial_pad,
  input  logic             cmp_gt_pad,
  input  logic             cmp_eq_pad,
  input  logic             cmp_lt_pad,
  output logic             busy_pad,
  output logic             done_pad,
  output logic [WIDTH-1:0] result_pad,
  output logic             exact_pad,
  output logic             err_pad
);

  localparam int C_BIT_W = $clog2(WIDTH);
  localparam int C_CNT_W = $clog2(CMP_LAT_MAX + 1);
  localparam logic [C_BIT_W-1:0] C_TOP = C_BIT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_LAT = C_CNT_W'(CMP_LAT);

  state_t             r_state,  w_state_nxt;
  logic [WIDTH-1:0]   r_acc,    w_acc_nxt;
  logic [C_BIT_W-1:0] r_bit,    w_bit_nxt;
  logic [C_CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic               r_exact,  w_exact_nxt;
  logic               r_err,    w_err_nxt;

  logic [WIDTH-1:0]   w_mask;
  logic [WIDTH-1:0]   w_trial;
  logic [WIDTH-1:0]   w_acc_dec;

  assign w_mask    = WIDTH'(1) << r_bit;
  assign w_trial   = r_acc | w_mask;
  assign w_acc_dec = cmp_lt_pad ? w_trial : r_acc;

  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exact  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_bit    <= w_bit_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_exact  <= w_exact_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_bit_nxt    = r_bit;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_exact_nxt  = r_exact;
    w_err_nxt    = r_err;
    trial_pad    = '0;
    busy_pad     = 1'b0;
    done_pad     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_pad) begin
          w_state_nxt  = SETTLE;
          w_acc_nxt    = '0;
          w_bit_nxt    = C_TOP;
          w_cnt_nxt    = C_LAT;
          w_result_nxt = '0;
          w_exact_nxt  = 1'b0;
          w_err_nxt    = 1'b0;
        end
      end

      SETTLE: begin
        trial_pad = w_trial;
        busy_pad  = 1'b1;
        // Flags are only trusted once the comparator latency has elapsed.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - C_CNT_W'(1);
        end else if (!onehot3(cmp_gt_pad, cmp_eq_pad, cmp_lt_pad)) begin
          w_err_nxt    = 1'b1;
          w_result_nxt = r_acc;
          w_state_nxt  = DONE;
        end else if (cmp_eq_pad) begin
          w_result_nxt = w_trial;
          w_exact_nxt  = 1'b1;
          w_state_nxt  = DONE;
        end else if (r_bit == '0) begin
          w_acc_nxt    = w_acc_dec;
          w_result_nxt = w_acc_dec;
          w_state_nxt  = DONE;
        end else begin
          w_acc_nxt = w_acc_dec;
          w_bit_nxt = r_bit - C_BIT_W'(1);
          w_cnt_nxt = C_LAT;
        end
      end

      DONE: begin
        done_pad    = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign result_pad = r_result;
  assign exact_pad  = r_exact;
  assign err_pad    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_sar_search_ctrl : directed bench, three controllers (CMP_LAT 0/1/2)     |
// | each paired with a behavioural comparator.                                 |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmp3_model #(
  parameter int WIDTH   = 16,
  parameter int CMP_LAT = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] trial,
  input  logic [WIDTH-1:0] unknown,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  logic [2:0] w_now;
  assign w_now = {trial > unknown, trial == unknown, trial < unknown};

  generate
    if (CMP_LAT == 0) begin : g_comb
      assign {gt, eq, lt} = w_now;
    end else begin : g_pipe
      logic [2:0] r_pipe [CMP_LAT];
      always_ff @(posedge clk) begin
        r_pipe[0] <= w_now;
        for (int i = 1; i < CMP_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
      assign {gt, eq, lt} = r_pipe[CMP_LAT-1];
    end
  endgenerate
endmodule

module tb_sar_search_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start   [3];
  logic [15:0] unk     [3];
  logic        ovr     [3];
  logic [2:0]  ovr_flg [3];
  logic [15:0] trial   [3];
  logic [15:0] result  [3];
  logic        busy    [3];
  logic        done    [3];
  logic        exact   [3];
  logic        err     [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_lane
      logic m_gt, m_eq, m_lt;
      logic d_gt, d_eq, d_lt;

      cmp3_model #(.WIDTH(16), .CMP_LAT(g)) u_cmp (
        .clk     (clk),
        .trial   (trial[g]),
        .unknown (unk[g]),
        .gt      (m_gt),
        .eq      (m_eq),
        .lt      (m_lt)
      );

      assign {d_gt, d_eq, d_lt} = ovr[g] ? ovr_flg[g] : {m_gt, m_eq, m_lt};

      sar_search_ctrl #(.WIDTH(16), .CMP_LAT(g)) u_dut (
        .clk_pad    (clk),
        .rst_pad    (rst),
        .start_pad  (start[g]),
        .trial_pad  (trial[g]),
        .cmp_gt_pad (d_gt),
        .cmp_eq_pad (d_eq),
        .cmp_lt_pad (d_lt),
        .busy_pad   (busy[g]),
        .done_pad   (done[g]),
        .result_pad (result[g]),
        .exact_pad  (exact[g]),
        .err_pad    (err[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge and checks the first trial appears.
  task automatic launch(input int ln, input logic [15:0] u);
    unk[ln]   = u;
    start[ln] = 1'b1;
    step();
    start[ln] = 1'b0;
    chk("busy_after_start", {31'd0, busy[ln]}, 32'd1);
    chk("trial_first", {16'd0, trial[ln]}, 32'h8000);
  endtask

  task automatic wait_done(input int ln, output int n);
    n = 0;
    while (done[ln] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic finish_chk(input string tag, input int ln, input int n, input int en,
                            input logic [15:0] r, input logic ex, input logic er);
    chk({tag, "_latency"}, n, en);
    chk({tag, "_done"},  {31'd0, done[ln]},  32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy[ln]}, 32'd0);
    chk({tag, "_trial_at_done"}, {16'd0, trial[ln]}, 32'd0);
    chk({tag, "_result"}, {16'd0, result[ln]}, {16'd0, r});
    chk({tag, "_exact"}, {31'd0, exact[ln]}, {31'd0, ex});
    chk({tag, "_err"},   {31'd0, err[ln]},   {31'd0, er});
    step();
    chk({tag, "_done_pulse"}, {31'd0, done[ln]}, 32'd0);
    chk({tag, "_busy_idle"}, {31'd0, busy[ln]}, 32'd0);
    chk({tag, "_result_held"}, {16'd0, result[ln]}, {16'd0, r});
    chk({tag, "_exact_held"}, {31'd0, exact[ln]}, {31'd0, ex});
  endtask

  initial begin : stim
    int n;
    logic [15:0] seq [7];
    seq[0] = 16'h8000; seq[1] = 16'h4000; seq[2] = 16'h2000; seq[3] = 16'h1000;
    seq[4] = 16'h1800; seq[5] = 16'h1400; seq[6] = 16'h1200;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; unk[i] = 16'h0; ovr[i] = 1'b0; ovr_flg[i] = 3'b000;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_trial",  {16'd0, trial[i]},  32'd0);
      chk("rst_result", {16'd0, result[i]}, 32'd0);
      chk("rst_busy",   {31'd0, busy[i]},   32'd0);
      chk("rst_done",   {31'd0, done[i]},   32'd0);
      chk("rst_exact",  {31'd0, exact[i]},  32'd0);
      chk("rst_err",    {31'd0, err[i]},    32'd0);
    end
    rst = 1'b0;
    step();

    // Early exit: first trial equals the unknown.
    launch(1, 16'h8000);
    step();
    chk("early_trial_k2", {16'd0, trial[1]}, 32'h8000);
    chk("early_no_done_k2", {31'd0, done[1]}, 32'd0);
    wait_done(1, n);
    finish_chk("early", 1, n + 1, 2, 16'h8000, 1'b1, 1'b0);

    // Exact match mid-search, with trial sequence tracking.
    launch(1, 16'h1234);
    for (int j = 1; j < 7; j++) begin
      step(); step();
      chk("mid_trial_seq", {16'd0, trial[1]}, {16'd0, seq[j]});
    end
    wait_done(1, n);
    finish_chk("mid", 1, n + 12, 28, 16'h1234, 1'b1, 1'b0);

    // Full search down to bit 0 with a combinational comparator.
    launch(0, 16'h0000);
    wait_done(0, n);
    finish_chk("full", 0, n, 16, 16'h0000, 1'b0, 1'b0);

    // Illegal flags at the first sample point.
    ovr[1] = 1'b1;
    ovr_flg[1] = 3'b101;
    launch(1, 16'h4321);
    wait_done(1, n);
    finish_chk("illegal", 1, n, 2, 16'h0000, 1'b0, 1'b1);
    ovr[1] = 1'b0;
    repeat (3) step();
    chk("illegal_err_held", {31'd0, err[1]}, 32'd1);
    launch(1, 16'h8000);
    chk("illegal_err_cleared", {31'd0, err[1]}, 32'd0);
    wait_done(1, n);
    finish_chk("after_err", 1, n, 2, 16'h8000, 1'b1, 1'b0);

    // Start held high: one search per IDLE visit.
    unk[2]   = 16'h00FF;
    start[2] = 1'b1;
    step();
    chk("hold_busy1", {31'd0, busy[2]}, 32'd1);
    wait_done(2, n);
    chk("hold_no_overlap1", {31'd0, busy[2] & done[2]}, 32'd0);
    finish_chk("hold1", 2, n, 48, 16'h00FF, 1'b1, 1'b0);
    step();
    chk("hold_restart_busy", {31'd0, busy[2]}, 32'd1);
    chk("hold_restart_trial", {16'd0, trial[2]}, 32'h8000);
    chk("hold_restart_clear", {16'd0, result[2]}, 32'd0);
    wait_done(2, n);
    chk("hold_no_overlap2", {31'd0, busy[2] & done[2]}, 32'd0);
    start[2] = 1'b0;
    finish_chk("hold2", 2, n, 48, 16'h00FF, 1'b1, 1'b0);
    step();
    chk("hold_stays_idle", {31'd0, busy[2]}, 32'd0);

    // Reset mid-search.
    launch(1, 16'h1234);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy",   {31'd0, busy[1]},   32'd0);
    chk("rst_mid_trial",  {16'd0, trial[1]},  32'd0);
    chk("rst_mid_result", {16'd0, result[1]}, 32'd0);
    chk("rst_mid_done",   {31'd0, done[1]},   32'd0);
    step();
    chk("rst_mid_idle", {31'd0, busy[1]}, 32'd0);
    launch(1, 16'h8000);
    wait_done(1, n);
    finish_chk("post_rst", 1, n, 2, 16'h8000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
